// File: rtl/piso_tx.sv
// piso_tx: UART transmitter that serialises bytes onto data_tx, one bit per baud_clk.
// Each frame is start(0), data LSB first, optional even parity, then stop(1).
// A one-entry holding register accepts the next byte while the current frame
// shifts out, so back-to-back frames leave no idle bit between them.
// Build option: define PISO_PARITY_EN for the 11-bit frame with even parity.
// Without it, the frame is 10 bits with no parity bit.
module piso_tx #(
  parameter int DATA_W = 8
) (
  input  logic              baud_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              data_tx,
  output logic              active_flag,
  output logic              tx_done
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_W = DATA_W + 3;
`else
  localparam int FRAME_W = DATA_W + 2;
`endif
  localparam logic [3:0] LAST_CNT = 4'(FRAME_W - 1);
  localparam logic [3:0] DATA_END = 4'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PISO_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_next;
  logic [3:0]           bit_cnt, cnt_next;
  logic [DATA_W-1:0]    hold_reg;
  logic                 hold_full;
  logic [FRAME_W-1:0]   shift_reg;
  logic [FRAME_W-1:0]   frame;
  logic                 load;
  logic                 accept;

  assign tx_ready    = !hold_full;
  assign accept      = tx_valid && !hold_full;
  assign data_tx     = shift_reg[0];
  assign active_flag = (state != IDLE);
  assign tx_done     = (state == STOP);

  // Frame image for the byte in the holding register, start bit in bit 0
  always_comb begin
`ifdef PISO_PARITY_EN
    frame = {1'b1, ^hold_reg, hold_reg, 1'b0};
`else
    frame = {1'b1, hold_reg, 1'b0};
`endif
  end

  // Next state and bit counter; a load starts a new frame from IDLE or the final stop cycle
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    load       = hold_full && ((state == IDLE) ||
                               ((state == STOP) && (bit_cnt == LAST_CNT)));
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (load) state_next = START;
      end
      START: begin
        state_next = DATA;
        cnt_next   = bit_cnt + 4'd1;
      end
      DATA: begin
        cnt_next = bit_cnt + 4'd1;
        if (bit_cnt == DATA_END) begin
`ifdef PISO_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_next = STOP;
        cnt_next   = bit_cnt + 4'd1;
      end
`endif
      STOP: begin
        cnt_next   = '0;
        state_next = load ? START : IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State register and bit counter
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
    end
  end

  // Holding register: filled on accept, emptied when its byte loads into the shifter
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_reg  <= tx_data;
      hold_full <= 1'b1;
    end
  end

  // Shifter: bit 0 drives the line; ones fill from the top so the line returns to idle-high after stop
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      shift_reg <= '1;
    end else if (load) begin
      shift_reg <= frame;
    end else if (state != IDLE) begin
      shift_reg <= {1'b1, shift_reg[FRAME_W-1:1]};
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: table-driven and randomized bench for piso_tx.
// The reference model keeps a queue of line bits still to be sent plus a one-byte holding slot.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int FW = 11;
  localparam logic [FW-1:0] LINE_A5 = 11'h54A;
  localparam logic [FW-1:0] LINE_3C = 11'h478;
  localparam logic [FW-1:0] LINE_01 = 11'h602;
  localparam logic [FW-1:0] LINE_FF = 11'h5FE;
`else
  localparam int FW = 10;
  localparam logic [FW-1:0] LINE_A5 = 10'h34A;
  localparam logic [FW-1:0] LINE_3C = 10'h278;
  localparam logic [FW-1:0] LINE_01 = 10'h202;
  localparam logic [FW-1:0] LINE_FF = 10'h3FE;
`endif

  logic       baud_clk = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] tx_data  = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, data_tx, active_flag, tx_done;

  piso_tx #(.DATA_W(8)) dut (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .tx_done     (tx_done)
  );

  always #5 baud_clk = ~baud_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  logic       pend[$];
  logic       m_full = 1'b0;
  logic [7:0] m_hold = '0;
  logic       m_tx = 1'b1, m_act = 1'b0, m_done = 1'b0;

  // Capture / statistics
  logic [63:0] cap;
  int          cap_n;
  logic        cap_en = 1'b0;
  int          dut_acc, done_cnt, act_cnt;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       e_tx;
    logic       e_act;
    logic       e_done;
    logic       e_rdy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    logic was_full;
    was_full = m_full;
    if (r) begin
      pend.delete();
      m_full = 1'b0;
      m_tx = 1'b1; m_act = 1'b0; m_done = 1'b0;
    end else begin
      if (was_full && pend.size() == 0) begin
        pend.push_back(1'b0);
        for (int k = 0; k < 8; k++) pend.push_back(m_hold[k]);
`ifdef PISO_PARITY_EN
        pend.push_back(^m_hold);
`endif
        pend.push_back(1'b1);
        m_full = 1'b0;
      end
      if (v && !was_full) begin
        m_hold = d;
        m_full = 1'b1;
      end
      if (pend.size() > 0) begin
        m_tx   = pend.pop_front();
        m_act  = 1'b1;
        m_done = (pend.size() == 0);
      end else begin
        m_tx = 1'b1; m_act = 1'b0; m_done = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst = r; tx_valid = v; tx_data = d;
    #1;
    if (!r && v && tx_ready) dut_acc++;
    @(posedge baud_clk);
    model_edge(r, v, d);
    #1;
    chk("model data_tx",     64'(data_tx),     64'(m_tx));
    chk("model active_flag", 64'(active_flag), 64'(m_act));
    chk("model tx_done",     64'(tx_done),     64'(m_done));
    chk("model tx_ready",    64'(tx_ready),    64'(!m_full));
    if (tx_done) done_cnt++;
    if (active_flag) act_cnt++;
    if (cap_en && active_flag) begin
      if (cap_n < 64) cap[cap_n] = data_tx;
      cap_n++;
    end
  endtask

  function automatic void add(input logic r, input logic v, input logic [7:0] d,
                              input logic etx, input logic eact, input logic edone,
                              input logic erdy);
    vec_t e;
    e.r = r; e.v = v; e.d = d;
    e.e_tx = etx; e.e_act = eact; e.e_done = edone; e.e_rdy = erdy;
    tbl.push_back(e);
  endfunction

  function automatic void add_frame(input logic [7:0] b, input logic [FW-1:0] line);
    add(1'b0, 1'b1, b, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < FW; k++)
      add(1'b0, 1'b0, 8'h00, line[k], 1'b1, (k == FW - 1), 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  initial begin
    logic [63:0] exp_bb;
    logic [7:0]  d;

    // Directed table: reset, idle, then two single frames from idle
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    add_frame(8'hA5, LINE_A5);
    add_frame(8'h3C, LINE_3C);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk("tbl data_tx",     64'(data_tx),     64'(tbl[i].e_tx));
      chk("tbl active_flag", 64'(active_flag), 64'(tbl[i].e_act));
      chk("tbl tx_done",     64'(tx_done),     64'(tbl[i].e_done));
      chk("tbl tx_ready",    64'(tx_ready),    64'(tbl[i].e_rdy));
    end

    // Back-to-back: valid held until two bytes are accepted
    step(1'b1, 1'b0, 8'h00);
    cap = '0; cap_n = 0; cap_en = 1'b1;
    dut_acc = 0; done_cnt = 0; act_cnt = 0;
    for (int i = 0; i < 2 * FW + 6; i++)
      step(1'b0, (dut_acc < 2), (dut_acc == 0) ? 8'h01 : 8'hFF);
    cap_en = 1'b0;
    exp_bb = 64'({LINE_FF, LINE_01});
    chk("b2b accepts",      64'(dut_acc),  64'd2);
    chk("b2b done pulses",  64'(done_cnt), 64'd2);
    chk("b2b active cycles",64'(act_cnt),  64'(2 * FW));
    chk("b2b line bits",    cap,           exp_bb);

    // Reset mid-frame at data bit 4 with a byte queued
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hC3);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("pre-reset active", 64'(active_flag), 64'd1);
    chk("pre-reset ready",  64'(tx_ready),    64'd0);
    step(1'b1, 1'b0, 8'h00);
    chk("reset data_tx",     64'(data_tx),     64'd1);
    chk("reset active_flag", 64'(active_flag), 64'd0);
    chk("reset tx_ready",    64'(tx_ready),    64'd1);
    act_cnt = 0;
    for (int i = 0; i < 2 * FW; i++) step(1'b0, 1'b0, 8'h00);
    chk("post-reset no frame", 64'(act_cnt), 64'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      d = 8'($urandom);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
